// File: rtl/conv_stats_pkg.sv
// Shared types and helpers for the convolution output statistics monitor.
package conv_stats_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2,
    TIMEOUT  = 2'd3
  } state_t;

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total + 1);
  endfunction

  // Start values chosen so the first non-zero sample always replaces them.
  function automatic logic [63:0] min_init(input int unsigned n, input bit is_signed);
    return is_signed ? ((64'd1 << (n - 1)) - 64'd1) : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] max_init(input int unsigned n, input bit is_signed);
    return is_signed ? (64'd1 << (n - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/stats_watchdog.sv
// Idle-cycle watchdog: reloads on every beat, flags expiry on the last tolerated idle cycle.
module stats_watchdog #(
  parameter int unsigned TIMEOUT_LIMIT = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned W = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_LIMIT);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || load) begin
      cnt <= '0;
    end else if (enable && cnt != LIMIT) begin
      cnt <= cnt + W'(1);
    end
  end

  // Combinational so the owner changes state on the cycle the limit is reached.
  assign expire_c = enable && (cnt == LAST);

endmodule

// File: rtl/conv_output_stats_monitor.sv
// Monitors a conv layer output stream: per-channel beat counts, non-zero min/max,
// completion, surplus beats, bad channels, early done and stalls.
module conv_output_stats_monitor
  import conv_stats_pkg::*;
#(
  parameter int unsigned N             = 16,
  parameter int unsigned OUT_CHANNELS  = 16,
  parameter int unsigned FEATURE_SIZE  = 112,
  parameter int unsigned TOTAL_OUTPUTS = FEATURE_SIZE * FEATURE_SIZE * OUT_CHANNELS,
  parameter int unsigned TIMEOUT_LIMIT = 10000000,
  parameter int unsigned SIGNED        = 1,
  parameter int unsigned CH_W          = ch_width(OUT_CHANNELS),
  parameter int unsigned CNT_W         = cnt_width(TOTAL_OUTPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [N-1:0]     data_in,
  input  logic [CH_W-1:0]  channel_in,
  input  logic             done_in,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] nonzero_count,
  output logic [N-1:0]     min_val,
  output logic [N-1:0]     max_val,
  output logic             busy,
  output logic             all_received,
  output logic             overflow,
  output logic             bad_channel,
  output logic             early_done,
  output logic             timeout
);

  localparam int unsigned IDX_W = ch_width(OUT_CHANNELS);
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_OUTPUTS);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL_OUTPUTS - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(OUT_CHANNELS);
  localparam logic [N-1:0]     MIN_INIT = N'(min_init(N, SIGNED != 0));
  localparam logic [N-1:0]     MAX_INIT = N'(max_init(N, SIGNED != 0));

  state_t state, state_d;
  logic accept_c, ch_ok_c, rd_ok_c, last_c, nz_c, lt_c, gt_c;
  logic wd_enable_c, wd_load_c, wd_expire_c;
  logic [IDX_W-1:0] ch_idx_c, rd_idx_c;
  logic [CNT_W-1:0] ch_count [OUT_CHANNELS];

  assign ch_ok_c  = {1'b0, channel_in} < CH_LIMIT;
  assign rd_ok_c  = {1'b0, rd_ch} < CH_LIMIT;
  assign ch_idx_c = IDX_W'(channel_in);
  assign rd_idx_c = IDX_W'(rd_ch);
  assign last_c   = (total_count == LAST);
  assign nz_c     = (data_in != '0);
  assign lt_c = (SIGNED != 0) ? ($signed(data_in) < $signed(min_val)) : (data_in < min_val);
  assign gt_c = (SIGNED != 0) ? ($signed(data_in) > $signed(max_val)) : (data_in > max_val);

  assign wd_enable_c = (state == COLLECT) && !valid_in;
  assign wd_load_c   = valid_in || (state != COLLECT);

  stats_watchdog #(
    .TIMEOUT_LIMIT(TIMEOUT_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (wd_load_c),
    .enable   (wd_enable_c),
    .expire_c (wd_expire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Beats are accepted only while idle or collecting; clear overrides everything.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          accept_c = 1'b1;
          state_d  = last_c ? COMPLETE : COLLECT;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          accept_c = 1'b1;
          if (last_c) state_d = COMPLETE;
        end else if (wd_expire_c) begin
          state_d = TIMEOUT;
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_d  = IDLE;
      accept_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_CHANNELS; i++) ch_count[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < OUT_CHANNELS; i++) ch_count[i] <= '0;
    end else begin
      for (int i = 0; i < OUT_CHANNELS; i++) begin
        if (accept_c && ch_ok_c && ch_idx_c == IDX_W'(i) && ch_count[i] != TOTAL)
          ch_count[i] <= ch_count[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count      <= '0;
      total_count   <= '0;
      nonzero_count <= '0;
      min_val       <= MIN_INIT;
      max_val       <= MAX_INIT;
      busy          <= 1'b0;
      all_received  <= 1'b0;
      overflow      <= 1'b0;
      bad_channel   <= 1'b0;
      early_done    <= 1'b0;
      timeout       <= 1'b0;
    end else if (clear) begin
      rd_count      <= '0;
      total_count   <= '0;
      nonzero_count <= '0;
      min_val       <= MIN_INIT;
      max_val       <= MAX_INIT;
      busy          <= 1'b0;
      all_received  <= 1'b0;
      overflow      <= 1'b0;
      bad_channel   <= 1'b0;
      early_done    <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      if (accept_c) begin
        if (total_count != TOTAL) total_count <= total_count + CNT_W'(1);
        if (nz_c) begin
          if (nonzero_count != TOTAL) nonzero_count <= nonzero_count + CNT_W'(1);
          if (lt_c) min_val <= data_in;
          if (gt_c) max_val <= data_in;
        end
        if (!ch_ok_c) bad_channel  <= 1'b1;
        if (last_c)   all_received <= 1'b1;
      end
      if (state == COMPLETE && valid_in) overflow <= 1'b1;
      if (state == COLLECT && done_in && total_count < TOTAL) early_done <= 1'b1;
      if (state_d == TIMEOUT) timeout <= 1'b1;
      busy     <= (state_d == COLLECT);
      // Sampled before this cycle's increment lands.
      rd_count <= rd_ok_c ? ch_count[rd_idx_c] : '0;
    end
  end

endmodule

// File: tb/tb_conv_output_stats_monitor.sv
// Directed bench for conv_output_stats_monitor in a 4-channel, 16-beat configuration.
module tb_conv_output_stats_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        valid_in;
  logic [15:0] data_in;
  logic [2:0]  channel_in;
  logic        done_in;
  logic [2:0]  rd_ch;
  logic [4:0]  rd_count, total_count, nonzero_count;
  logic [15:0] min_val, max_val;
  logic        busy, all_received, overflow, bad_channel, early_done, timeout;

  int n_vec = 0;
  int n_err = 0;

  conv_output_stats_monitor #(
    .N(16), .OUT_CHANNELS(4), .FEATURE_SIZE(2), .TOTAL_OUTPUTS(16),
    .TIMEOUT_LIMIT(20), .SIGNED(1), .CH_W(3), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .channel_in(channel_in), .done_in(done_in), .rd_ch(rd_ch), .rd_count(rd_count),
    .total_count(total_count), .nonzero_count(nonzero_count), .min_val(min_val),
    .max_val(max_val), .busy(busy), .all_received(all_received), .overflow(overflow),
    .bad_channel(bad_channel), .early_done(early_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] data;
    logic [4:0]  exp_total;
    logic [4:0]  exp_nz;
    logic [15:0] exp_min;
    logic [15:0] exp_max;
  } vec_t;

  vec_t frame [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] ch, input logic [15:0] d);
    valid_in   = 1'b1;
    channel_in = ch;
    data_in    = d;
    tick();
    valid_in   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic read_ch(input logic [2:0] c, input logic [4:0] exp);
    rd_ch = c;
    tick();
    check($sformatf("rd_count ch%0d", c), 64'(rd_count), 64'(exp));
  endtask

  // flag order: busy, all_received, overflow, bad_channel, early_done, timeout
  task automatic check_flags(input string name, input logic [5:0] exp);
    check(name, 64'({busy, all_received, overflow, bad_channel, early_done, timeout}), 64'(exp));
  endtask

  task automatic check_stats(input string name, input logic [4:0] t, input logic [4:0] nz,
                             input logic [15:0] mn, input logic [15:0] mx);
    check(name, 64'({total_count, nonzero_count, min_val, max_val}), 64'({t, nz, mn, mx}));
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 16; i++) begin
      beat(frame[i].ch, frame[i].data);
      check_stats($sformatf("%s beat%0d", tag, i), frame[i].exp_total, frame[i].exp_nz,
                  frame[i].exp_min, frame[i].exp_max);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit expired");
    $fatal(1, "time limit");
  end

  initial begin
    // data = k-8, channel = k%4; zero at k=8 leaves nonzero and max untouched
    frame[0]  = '{3'd0, 16'hFFF8, 5'd1,  5'd1,  16'hFFF8, 16'hFFF8};
    frame[1]  = '{3'd1, 16'hFFF9, 5'd2,  5'd2,  16'hFFF8, 16'hFFF9};
    frame[2]  = '{3'd2, 16'hFFFA, 5'd3,  5'd3,  16'hFFF8, 16'hFFFA};
    frame[3]  = '{3'd3, 16'hFFFB, 5'd4,  5'd4,  16'hFFF8, 16'hFFFB};
    frame[4]  = '{3'd0, 16'hFFFC, 5'd5,  5'd5,  16'hFFF8, 16'hFFFC};
    frame[5]  = '{3'd1, 16'hFFFD, 5'd6,  5'd6,  16'hFFF8, 16'hFFFD};
    frame[6]  = '{3'd2, 16'hFFFE, 5'd7,  5'd7,  16'hFFF8, 16'hFFFE};
    frame[7]  = '{3'd3, 16'hFFFF, 5'd8,  5'd8,  16'hFFF8, 16'hFFFF};
    frame[8]  = '{3'd0, 16'h0000, 5'd9,  5'd8,  16'hFFF8, 16'hFFFF};
    frame[9]  = '{3'd1, 16'h0001, 5'd10, 5'd9,  16'hFFF8, 16'h0001};
    frame[10] = '{3'd2, 16'h0002, 5'd11, 5'd10, 16'hFFF8, 16'h0002};
    frame[11] = '{3'd3, 16'h0003, 5'd12, 5'd11, 16'hFFF8, 16'h0003};
    frame[12] = '{3'd0, 16'h0004, 5'd13, 5'd12, 16'hFFF8, 16'h0004};
    frame[13] = '{3'd1, 16'h0005, 5'd14, 5'd13, 16'hFFF8, 16'h0005};
    frame[14] = '{3'd2, 16'h0006, 5'd15, 5'd14, 16'hFFF8, 16'h0006};
    frame[15] = '{3'd3, 16'h0007, 5'd16, 5'd15, 16'hFFF8, 16'h0007};

    rst = 1'b0; clear = 1'b0; valid_in = 1'b0; data_in = '0;
    channel_in = '0; done_in = 1'b0; rd_ch = '0;
    tick();
    tick();
    check_stats("reset stats", 5'd0, 5'd0, 16'h7FFF, 16'h8000);
    check_flags("reset flags", 6'b000000);
    check("reset rd_count", 64'(rd_count), 64'd0);
    rst = 1'b1;
    tick();

    // full frame, readout per channel, out-of-range readout
    run_frame("frameA");
    check_flags("frameA flags", 6'b010000);
    for (int c = 0; c < 4; c++) read_ch(3'(c), 5'd4);
    read_ch(3'd5, 5'd0);

    // surplus beat after completion
    beat(3'd0, 16'h0003);
    check_flags("overflow flags", 6'b011000);
    check_stats("overflow stats", 5'd16, 5'd15, 16'hFFF8, 16'h0007);
    read_ch(3'd0, 5'd4);

    // watchdog: 5 beats then 20 idle cycles
    do_clear();
    check_stats("clear stats", 5'd0, 5'd0, 16'h7FFF, 16'h8000);
    check_flags("clear flags", 6'b000000);
    for (int k = 0; k < 5; k++) beat(3'd0, 16'h0001);
    check_flags("collect flags", 6'b100000);
    repeat (19) tick();
    check_flags("idle19 flags", 6'b100000);
    tick();
    check_flags("timeout flags", 6'b000001);
    beat(3'd1, 16'h0001);
    check_stats("timeout stats", 5'd5, 5'd5, 16'h0001, 16'h0001);
    read_ch(3'd1, 5'd0);

    // invalid channel index
    do_clear();
    beat(3'd5, 16'h0002);
    check_stats("badch stats", 5'd1, 5'd1, 16'h0002, 16'h0002);
    check_flags("badch flags", 6'b100100);
    read_ch(3'd1, 5'd0);
    read_ch(3'd5, 5'd0);

    // done in IDLE ignored; done mid-frame flags early_done
    do_clear();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check_flags("idle done flags", 6'b000000);
    for (int k = 0; k < 10; k++) beat(3'(k % 4), 16'(k + 1));
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check_flags("early_done flags", 6'b100010);
    for (int k = 10; k < 16; k++) beat(3'(k % 4), 16'(k + 1));
    check_flags("early_done end flags", 6'b010010);
    check_stats("early_done stats", 5'd16, 5'd16, 16'h0001, 16'h0010);

    // async reset at beat 8, then a fresh frame
    do_clear();
    for (int i = 0; i < 8; i++) beat(frame[i].ch, frame[i].data);
    #2 rst = 1'b0;
    #1;
    check_stats("async rst stats", 5'd0, 5'd0, 16'h7FFF, 16'h8000);
    check_flags("async rst flags", 6'b000000);
    tick();
    rst = 1'b1;
    run_frame("frameB");
    check_flags("frameB flags", 6'b010000);
    read_ch(3'd2, 5'd4);

    // clear wins over a simultaneous beat
    do_clear();
    for (int i = 0; i < 3; i++) beat(frame[i].ch, frame[i].data);
    clear = 1'b1;
    valid_in = 1'b1; channel_in = 3'd0; data_in = 16'h0005;
    tick();
    clear = 1'b0; valid_in = 1'b0;
    check_stats("clear+valid stats", 5'd0, 5'd0, 16'h7FFF, 16'h8000);
    check_flags("clear+valid flags", 6'b000000);
    read_ch(3'd0, 5'd0);

    // read and beat on the same channel in the same cycle
    rd_ch = 3'd0;
    beat(3'd0, 16'h0001);
    check("rd collide", 64'(rd_count), 64'd0);
    tick();
    check("rd after", 64'(rd_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
